// File: rtl/fp_comp_if.sv
// fp_comp_if: groups the handshake and operand signals between the FCC unit
// (master) and the floating-point compare core (slave). clk/resetn stay as
// plain ports on the core.
//   valid, op_a, op_b, opsng, cmp_cond : request (master -> slave)
//   a_wait, flush                      : downstream stall / pipeline flush
//   busy, ready, result, invalid       : status and result (slave -> master)
interface fp_comp_if;
  logic        valid;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        opsng;
  logic [3:0]  cmp_cond;
  logic        a_wait;
  logic        flush;
  logic        busy;
  logic        ready;
  logic        result;
  logic        invalid;

  modport master (
    output valid, op_a, op_b, opsng, cmp_cond, a_wait, flush,
    input  busy, ready, result, invalid
  );

  modport slave (
    input  valid, op_a, op_b, opsng, cmp_cond, a_wait, flush,
    output busy, ready, result, invalid
  );
endinterface

// File: rtl/fp_comp.sv
// fp_comp: MIPS C.cond.fmt compare core (single/double). Two-stage,
// non-pipelined: operands are latched on accept, the predicate and the
// invalid-operation flag are registered on the following edge.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : fp_comp_if.slave (request, stall/flush, busy/ready/result/invalid)
//
// state    | meaning
// ST_IDLE  | no operation in flight, accepts valid
// ST_EVAL  | operands latched (stage-1 valid), result computed this cycle
// ST_DONE  | ready high, result/invalid presented; held while a_wait
module fp_comp (
  input  logic       clk,
  input  logic       resetn,
  fp_comp_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] a_q, b_q;
  logic        sng_q;
  logic [3:0]  cond_q;
  logic        result_q, invalid_q;
  logic        result_d, invalid_d;

  // Operand classification on the latched operands
  logic [62:0] mag_a, mag_b;
  logic        sign_a, sign_b;
  logic        nan_a, nan_b, snan_a, snan_b;
  logic        un, eq, lt, zero_both;

  always_comb begin
    // Single format: upper word ignored, magnitude zero-extended so the same
    // unsigned compare serves both formats.
    mag_a  = sng_q ? {32'b0, a_q[30:0]} : a_q[62:0];
    mag_b  = sng_q ? {32'b0, b_q[30:0]} : b_q[62:0];
    sign_a = sng_q ? a_q[31] : a_q[63];
    sign_b = sng_q ? b_q[31] : b_q[63];
    nan_a  = sng_q ? ((a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0))
                   : ((a_q[62:52] == 11'h7FF) && (a_q[51:0] != 52'd0));
    nan_b  = sng_q ? ((b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0))
                   : ((b_q[62:52] == 11'h7FF) && (b_q[51:0] != 52'd0));
    // Quiet bit is the fraction MSB; clear means signaling
    snan_a = nan_a && !(sng_q ? a_q[22] : a_q[51]);
    snan_b = nan_b && !(sng_q ? b_q[22] : b_q[51]);

    un        = nan_a || nan_b;
    zero_both = (mag_a == 63'd0) && (mag_b == 63'd0);
    eq        = !un && (((sign_a == sign_b) && (mag_a == mag_b)) || zero_both);
    if (un)
      lt = 1'b0;
    else if (sign_a != sign_b)
      lt = sign_a && !zero_both;
    else if (!sign_a)
      lt = mag_a < mag_b;
    else
      lt = mag_a > mag_b;

    result_d  = (cond_q[0] && un) || (cond_q[1] && eq) || (cond_q[2] && lt);
    invalid_d = snan_a || snan_b || (cond_q[3] && un);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sng_q     <= 1'b0;
      cond_q    <= '0;
      result_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q   <= ST_IDLE;
      result_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            sng_q   <= bus.opsng;
            cond_q  <= bus.cmp_cond;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          result_q  <= result_d;
          invalid_q <= invalid_d;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.a_wait) begin
            result_q  <= 1'b0;
            invalid_q <= 1'b0;
            // busy is already low here, so a request on this edge is legal
            if (bus.valid) begin
              a_q     <= bus.op_a;
              b_q     <= bus.op_b;
              sng_q   <= bus.opsng;
              cond_q  <= bus.cmp_cond;
              state_q <= ST_EVAL;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready   = (state_q == ST_DONE);
  assign bus.result  = result_q;
  assign bus.invalid = invalid_q;
  assign bus.busy    = (state_q == ST_EVAL) || ((state_q == ST_DONE) && bus.a_wait);

endmodule

// File: tb/tb_fp_comp.sv
module tb_fp_comp;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  fp_comp_if bus ();

  fp_comp dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sng;
    logic [3:0]  cond;
    logic        res;
    logic        inv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [63:0] a, input logic [63:0] b,
                     input logic sng, input logic [3:0] cond, input logic res, input logic inv);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.sng = sng; v.cond = cond; v.res = res; v.inv = inv;
    vecs.push_back(v);
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.opsng    = v.sng;
    bus.cmp_cond = v.cond;
    bus.valid    = 1'b1;
    @(negedge clk);
    bus.valid    = 1'b0;
  endtask

  // Waits (bounded) for ready; returns number of negedges after valid's edge
  task automatic wait_ready(input string name, output int n);
    n = 1;
    while (!bus.ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start_op(v);
    chk({v.name, "_busy1"}, {63'd0, bus.busy}, 64'd1);
    wait_ready(v.name, n);
    chk({v.name, "_lat"}, 64'(n), 64'd2);
    chk({v.name, "_res"}, {63'd0, bus.result}, {63'd0, v.res});
    chk({v.name, "_inv"}, {63'd0, bus.invalid}, {63'd0, v.inv});
    chk({v.name, "_busy0"}, {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk({v.name, "_rdyclr"}, {63'd0, bus.ready}, 64'd0);
  endtask

  localparam logic [63:0] S1P0  = 64'h3F800000;
  localparam logic [63:0] S2P0  = 64'h40000000;
  localparam logic [63:0] SQNAN = 64'h7FC00000;
  localparam logic [63:0] SSNAN = 64'h7FA00000;

  initial begin
    vec_t v;
    int   n;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.opsng = 1'b0;
    bus.cmp_cond = '0; bus.a_wait = 1'b0; bus.flush = 1'b0;

    add("s_lt",        S1P0, S2P0, 1'b1, 4'hC, 1'b1, 1'b0);
    add("s_lt_swap",   S2P0, S1P0, 1'b1, 4'hC, 1'b0, 1'b0);
    add("d_eq_zero",   64'h8000000000000000, 64'h0, 1'b0, 4'h2, 1'b1, 1'b0);
    add("d_ole_neg",   64'hBFF0000000000000, 64'hC000000000000000, 1'b0, 4'h6, 1'b0, 1'b0);
    add("d_lt_neg",    64'hC000000000000000, 64'hBFF0000000000000, 1'b0, 4'h4, 1'b1, 1'b0);
    add("s_un_qnan",   SQNAN, S1P0, 1'b1, 4'h1, 1'b1, 1'b0);
    add("s_ngle_qnan", SQNAN, S1P0, 1'b1, 4'h9, 1'b1, 1'b1);
    add("s_eq_snan",   SSNAN, S1P0, 1'b1, 4'h2, 1'b0, 1'b1);
    add("s_f_snan",    S1P0, SSNAN, 1'b1, 4'h0, 1'b0, 1'b1);
    add("s_sf_qnan",   SQNAN, S1P0, 1'b1, 4'h8, 1'b0, 1'b1);
    add("s_sf_num",    S1P0, S2P0, 1'b1, 4'h8, 1'b0, 1'b0);
    add("s_upper_gb",  64'hFFFFFFFF3F800000, 64'hFFFFFFFF40000000, 1'b1, 4'h4, 1'b1, 1'b0);
    add("s_lt_zeros",  64'h80000000, 64'h0, 1'b1, 4'h4, 1'b0, 1'b0);
    add("s_lt_sign",   64'hBF800000, S1P0, 1'b1, 4'h4, 1'b1, 1'b0);
    add("s_ueq_inf",   64'h7F800000, 64'h7F800000, 1'b1, 4'h3, 1'b1, 1'b0);
    add("s_lt_denorm", 64'h00000001, 64'h00000002, 1'b1, 4'h4, 1'b1, 1'b0);
    add("d_lt_inf",    64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 1'b0, 4'h4, 1'b0, 1'b0);
    add("d_fmt_sel",   64'h0000000100000000, 64'h1, 1'b0, 4'h4, 1'b0, 1'b0);
    add("s_fmt_sel",   64'h0000000100000000, 64'h1, 1'b1, 4'h4, 1'b1, 1'b0);
    add("d_nan_lowbits", 64'h000000007FC00000, 64'h0, 1'b0, 4'h1, 1'b0, 1'b0);
    add("d_sle_qnan",  64'h7FF8000000000000, 64'h0, 1'b0, 4'hE, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("rst_busy",    {63'd0, bus.busy},    64'd0);
    chk("rst_ready",   {63'd0, bus.ready},   64'd0);
    chk("rst_result",  {63'd0, bus.result},  64'd0);
    chk("rst_invalid", {63'd0, bus.invalid}, 64'd0);
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall: a_wait held three cycles while ready
    v = vecs[0];
    bus.a_wait = 1'b1;
    start_op(v);
    wait_ready("stall", n);
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready",  {63'd0, bus.ready},  64'd1);
      chk("stall_result", {63'd0, bus.result}, 64'd1);
      chk("stall_busy",   {63'd0, bus.busy},   64'd1);
      if (k < 2) @(negedge clk);
    end
    bus.a_wait = 1'b0;
    @(negedge clk);
    chk("stall_rdyclr", {63'd0, bus.ready},  64'd0);
    chk("stall_resclr", {63'd0, bus.result}, 64'd0);
    chk("stall_busy0",  {63'd0, bus.busy},   64'd0);

    // Flush one cycle after valid: result dropped
    start_op(v);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy",  {63'd0, bus.busy},  64'd0);
    chk("flush_ready", {63'd0, bus.ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_noready", {63'd0, bus.ready}, 64'd0);
    end

    // Flush together with valid: request not accepted
    @(negedge clk);
    bus.op_a = S1P0; bus.op_b = S2P0; bus.opsng = 1'b1; bus.cmp_cond = 4'hC;
    bus.valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0; bus.flush = 1'b0;
    chk("flushv_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk("flushv_ready", {63'd0, bus.ready}, 64'd0);

    // Back-to-back still works after flushes
    run_vec(vecs[6]);

    // Reset while a stalled result is presented
    bus.a_wait = 1'b1;
    start_op(vecs[6]);
    wait_ready("rstmid", n);
    chk("rstmid_pre_inv", {63'd0, bus.invalid}, 64'd1);
    resetn = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("rstmid_busy",    {63'd0, bus.busy},    64'd0);
    chk("rstmid_ready",   {63'd0, bus.ready},   64'd0);
    chk("rstmid_result",  {63'd0, bus.result},  64'd0);
    chk("rstmid_invalid", {63'd0, bus.invalid}, 64'd0);
    bus.a_wait = 1'b0;

    // Reset one cycle after valid (operation in stage 1)
    resetn = 1'b1;
    start_op(vecs[0]);
    resetn = 1'b0;
    @(negedge clk);
    chk("rsts1_busy",  {63'd0, bus.busy},  64'd0);
    chk("rsts1_ready", {63'd0, bus.ready}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rsts1_noready", {63'd0, bus.ready}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_comp.md
# fp_comp

Floating-point compare core for the FPU's FCC unit. It evaluates MIPS `C.cond.fmt` predicates on single- or double-precision operands and returns a 1-bit condition plus an IEEE invalid-operation flag. It is a two-stage, non-pipelined block with busy/ready handshake, downstream stall (`a_wait`) and `flush`. The parent unit writes the result into `FCC[fcc_addr]` on `ready`.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `a_wait` in 1: downstream stall; holds a presented result.
- `flush` in 1: pipeline flush; discards any operation in flight.
- `busy` out 1: high when the block cannot accept `valid`.
- `valid` in 1: start request. The parent only drives it when `busy`, `a_wait` and `ready` are all low.
- `op_a` in 64: first operand (fs). Single precision uses `[31:0]`; `[63:32]` is ignored.
- `op_b` in 64: second operand (ft). Same packing as `op_a`.
- `opsng` in 1: 1 = single (S) format, 0 = double (D) format.
- `cmp_cond` in 4: MIPS cond field, bit-encoded as follows:
  - `[0]` unordered
  - `[1]` equal
  - `[2]` less
  - `[3]` signaling
- `ready` out 1: result valid.
- `result` out 1: predicate value, meaningful while `ready` is high.
- `invalid` out 1: invalid-operation flag, meaningful while `ready` is high.

## Operation
- Classification per format:
  - Single: exponent `[30:23]`, fraction `[22:0]`.
  - Double: exponent `[62:52]`, fraction `[51:0]`.
  - NaN: exponent all ones and fraction nonzero.
  - sNaN: NaN with fraction MSB = 0. qNaN: fraction MSB = 1 (IEEE 754-2008 convention).
- `un` = either operand is NaN.
- When not `un`:
  - `eq` = bit patterns are identical, or both operands are ±0 (+0 == −0).
  - `lt` uses sign-magnitude ordering:
    - signs differ: a < b iff a is negative and not both zero;
    - both positive: a < b iff mag(a) < mag(b);
    - both negative: a < b iff mag(a) > mag(b).
  - Infinities and denormals compare exactly by their encoding.
- When `un`: `eq = lt = 0`.
- `result = (cmp_cond[0] & un) | (cmp_cond[1] & eq) | (cmp_cond[2] & lt)`.
- `invalid = (either operand is sNaN) | (cmp_cond[3] & un)`.
- Cond 0 (F) and cond 8 (SF) always return `result` = 0; SF can still raise `invalid`.
- Only one operation is in flight at a time. `valid` while `busy` is a protocol violation and is ignored.

## Timing
- Reset values: `busy` = 0, `ready` = 0, `result` = 0, `invalid` = 0; internal stage-valid flags = 0.
- Stage 1: on the edge where `valid` = 1 and the block is idle, latch the operands and control and set s1_valid. `busy` = 1 in the following cycle.
- Stage 2: on the next edge, register `result`/`invalid`, clear s1_valid and set `ready`.
- Latency: `valid` sampled at edge E0 → `ready` high in the cycle after E1.
- `ready` holds for one cycle when `a_wait` = 0. While `a_wait` = 1, `ready`, `result` and `invalid` stay stable; they clear on the first edge with `a_wait` = 0.
- `busy` = s1_valid | (`ready` & `a_wait`).
- `ready` and `result`/`invalid` are registered outputs (no combinational path from the inputs).
- Flush: on an edge with `flush` = 1, clear s1_valid and `ready`. Flush beats a simultaneous `valid` (not accepted) and stage advance (result dropped). The next cycle is idle.
- Reset takes priority over `flush`.

## Test plan
- Single C.LT (cond 0xC):
  - a = 0x3F800000 (1.0), b = 0x40000000 (2.0) → `ready` two edges later, `result` = 1, `invalid` = 0, `busy` high for exactly one cycle.
  - Swapped operands → `result` = 0.
- Double C.EQ (cond 2): a = 0x8000000000000000 (−0), b = 0 → `result` = 1.
- Double C.OLE (cond 6): a = 0xBFF0000000000000 (−1.0), b = 0xC000000000000000 (−2.0) → `result` = 0.
- NaN handling, single:
  - C.UN (cond 1) with a = 0x7FC00000 (qNaN), b = 1.0 → `result` = 1, `invalid` = 0.
  - Same operands with C.NGLE (cond 9) → `result` = 1, `invalid` = 1.
  - C.EQ (cond 2) with sNaN 0x7FA00000 → `result` = 0, `invalid` = 1.
- Stall and flush:
  - `a_wait` = 1 for 3 cycles while `ready` → `ready`/`result` held stable, `busy` = 1; `ready` clears one edge after `a_wait` drops.
  - `flush` one cycle after `valid` → `ready` never asserts, `busy` low the next cycle.
- Single-format upper bits: `op_a[63:32]` = 0xFFFFFFFF garbage with `opsng` = 1 → result unaffected. Synchronous reset mid-operation → all outputs 0 on the next cycle.
